// File: rtl/mod_updown_counter_if.sv
// rtl/mod_updown_counter_if.sv - control/status bundle for mod_updown_counter
interface mod_updown_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             select;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;

   modport master (
      output en, select, clr, load, load_val,
      input  count, tc, ovf
   );

   modport slave (
      input  en, select, clr, load, load_val,
      output count, tc, ovf
   );
endinterface

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - up/down counter with modulus, prescaler, wrap/saturate, tc and sticky ovf
module mod_updown_counter #(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 2**WIDTH - 1,
   parameter int PRESCALE = 1,
   parameter int SATURATE = 0
) (
   input  logic               clk,
   input  logic               rst,
   mod_updown_counter_if.slave bus
);

   // Prescaler needs at least one bit even when PRESCALE=1 (it then stays 0).
   localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_VAL);
   localparam logic [PW-1:0]    PRE_TOP = PW'(PRESCALE - 1);

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             step;
   logic             at_bound;

   // Next-state: clr beats load beats step; tc is a one-cycle boundary marker.
   always_comb begin
      count_d  = count_q;
      pre_d    = pre_q;
      tc_d     = 1'b0;
      ovf_d    = ovf_q;
      step     = 1'b0;
      at_bound = 1'b0;
      if (bus.clr) begin
         count_d = '0;
         pre_d   = '0;
         ovf_d   = 1'b0;
      end else if (bus.load) begin
         count_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
         pre_d   = '0;
      end else if (bus.en) begin
         if (pre_q == PRE_TOP) begin
            pre_d = '0;
            step  = 1'b1;
         end else begin
            pre_d = pre_q + PW'(1);
         end
         if (step) begin
            if (bus.select) begin
               at_bound = (count_q == MAX_V);
               if (!at_bound)
                  count_d = count_q + WIDTH'(1);
               else if (SATURATE == 0)
                  count_d = '0;
            end else begin
               at_bound = (count_q == '0);
               if (!at_bound)
                  count_d = count_q - WIDTH'(1);
               else if (SATURATE == 0)
                  count_d = MAX_V;
            end
            if (at_bound) begin
               tc_d  = 1'b1;
               ovf_d = 1'b1;
            end
         end
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         pre_q   <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - scoreboard bench for mod_updown_counter
module tb_mod_updown_counter;

   typedef struct {
      bit         which;
      logic [3:0] cnt;
      logic       tc;
      logic       ovf;
      string      tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   // DUT a: wrap mode, prescale 2, modulus 10.
   mod_updown_counter_if #(.WIDTH(4)) bus_a ();
   mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(2), .SATURATE(0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   // DUT b: saturate mode, no prescale, modulus 10.
   mod_updown_counter_if #(.WIDTH(4)) bus_b ();
   mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive one edge of stimulus on one DUT (other idles) and queue its expected result.
   task automatic drive(input bit which, input logic e, input logic s, input logic c,
                        input logic l, input logic [3:0] lv,
                        input logic [3:0] ec, input logic et, input logic eo, input string tag);
      exp_t x;
      @(negedge clk);
      if (!which) begin
         bus_a.en = e; bus_a.select = s; bus_a.clr = c; bus_a.load = l; bus_a.load_val = lv;
         bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.load = 1'b0;
      end else begin
         bus_b.en = e; bus_b.select = s; bus_b.clr = c; bus_b.load = l; bus_b.load_val = lv;
         bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.load = 1'b0;
      end
      x.which = which; x.cnt = ec; x.tc = et; x.ovf = eo; x.tag = tag;
      exp_q.push_back(x);
   endtask

   // Compare each queued expectation just after the edge it belongs to.
   initial begin
      exp_t x;
      logic [7:0] obs;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            obs = x.which ? {2'b00, bus_b.count, bus_b.tc, bus_b.ovf}
                          : {2'b00, bus_a.count, bus_a.tc, bus_a.ovf};
            check(x.tag, obs, {2'b00, x.cnt, x.tc, x.ovf});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus_a.en = 0; bus_a.select = 0; bus_a.clr = 0; bus_a.load = 0; bus_a.load_val = 0;
      bus_b.en = 0; bus_b.select = 0; bus_b.clr = 0; bus_b.load = 0; bus_b.load_val = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", {2'b00, bus_a.count, bus_a.tc, bus_a.ovf}, 8'h00);
      check("reset_b", {2'b00, bus_b.count, bus_b.tc, bus_b.ovf}, 8'h00);
      @(negedge clk);
      rst = 1'b0;

      // 1: count up with prescale 2, wrap 9->0 on the 20th edge
      for (int k = 1; k <= 20; k++)
         drive(0, 1, 1, 0, 0, 4'd0, 4'((k / 2) % 10), (k == 20), (k >= 20), "t1_up");

      // 2: load 3, count down through 0 to 9
      drive(0, 0, 0, 0, 1, 4'd3, 4'd3, 0, 1, "t2_load");
      for (int j = 1; j <= 8; j++)
         drive(0, 1, 0, 0, 0, 4'd0, (j == 8) ? 4'd9 : 4'(3 - j / 2), (j == 8), 1, "t2_down");

      // 3: clamp on load, clr beats load and clears ovf
      drive(0, 0, 0, 0, 1, 4'd15, 4'd9, 0, 1, "t3_clamp");
      drive(0, 0, 0, 1, 1, 4'd15, 4'd0, 0, 0, "t3_clr");

      // 5: en gaps freeze the prescaler phase
      drive(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0, "t5_en1");
      drive(0, 0, 1, 0, 0, 4'd0, 4'd0, 0, 0, "t5_en0");
      drive(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0, "t5_en1b");

      // 6a: count A up to 5
      for (int j = 1; j <= 8; j++)
         drive(0, 1, 1, 0, 0, 4'd0, 4'(1 + j / 2), 0, 0, "t6_up");

      // 4: saturate on DUT b, tc held high while pinned at the top
      for (int k = 1; k <= 9; k++)
         drive(1, 1, 1, 0, 0, 4'd0, 4'(k), 0, 0, "t4_up");
      for (int k = 1; k <= 3; k++)
         drive(1, 1, 1, 0, 0, 4'd0, 4'd9, 1, 1, "t4_hold");
      drive(1, 1, 0, 0, 0, 4'd0, 4'd8, 0, 1, "t4_down");
      drive(1, 1, 0, 0, 1, 4'd0, 4'd0, 0, 1, "t4_load0");
      drive(1, 1, 0, 0, 0, 4'd0, 4'd0, 1, 1, "t4_bot");
      drive(1, 0, 0, 0, 1, 4'd12, 4'd9, 0, 1, "t4_clamp");

      // 6b: asynchronous reset between edges, then resume
      @(posedge clk);
      #3;
      check("t6_pre_a", {4'h0, bus_a.count}, 8'h05);
      rst = 1'b1;
      #1;
      check("t6_async_a", {2'b00, bus_a.count, bus_a.tc, bus_a.ovf}, 8'h00);
      check("t6_async_b", {2'b00, bus_b.count, bus_b.tc, bus_b.ovf}, 8'h00);
      @(posedge clk);
      #1;
      check("t6_held_a", {2'b00, bus_a.count, bus_a.tc, bus_a.ovf}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 1, 0, 0, 4'd0, 4'd0, 0, 0, "t6_resume0");
      drive(0, 1, 1, 0, 0, 4'd0, 4'd1, 0, 0, "t6_resume1");

      @(negedge clk);
      bus_a.en = 0;
      bus_b.en = 0;
      repeat (2) @(posedge clk);
      #2;
      check("queue_empty", 8'(exp_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
